// File: rtl/sha2_pkg.sv
// ---------------------------------------------------------------------------
// sha2_pkg
// Shared definitions for the SHA-2 message scheduler slice.
// Holds the scheduler state encoding, the sigma rotate/shift amounts for the
// 32-bit (SHA-224/256) and 64-bit (SHA-384/512) word widths, the schedule
// lengths for each family, and a helper that maps a word width to its
// schedule length.
// ---------------------------------------------------------------------------
package sha2_pkg;

    // Scheduler control states: waiting, filling the window, streaming W[t].
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND
    } state_e;

    // Number of schedule words produced per block for each family.
    localparam int ROUNDS_256 = 64;
    localparam int ROUNDS_512 = 80;

    // The sliding window holds the last sixteen schedule words.
    localparam int WINDOW_WORDS = 16;

    // Small sigma amounts for 32-bit words.
    localparam int S0_ROT_A_256 = 7;
    localparam int S0_ROT_B_256 = 18;
    localparam int S0_SHR_256   = 3;
    localparam int S1_ROT_A_256 = 17;
    localparam int S1_ROT_B_256 = 19;
    localparam int S1_SHR_256   = 10;

    // Small sigma amounts for 64-bit words.
    localparam int S0_ROT_A_512 = 1;
    localparam int S0_ROT_B_512 = 8;
    localparam int S0_SHR_512   = 7;
    localparam int S1_ROT_A_512 = 19;
    localparam int S1_ROT_B_512 = 61;
    localparam int S1_SHR_512   = 6;

    // Schedule length that belongs to a given word width.
    function automatic int roundsFor(input int width);
        return (width == 64) ? ROUNDS_512 : ROUNDS_256;
    endfunction

endpackage

// File: rtl/msg_sigma.sv
// ---------------------------------------------------------------------------
// msg_sigma
// Purely combinational small-sigma pair used by the message scheduler.
// Ports:
//   sig0Src_i  word fed to sigma0 (the scheduler's window[1], i.e. W[t-15])
//   sig1Src_i  word fed to sigma1 (the scheduler's window[14], i.e. W[t-2])
//   sigma0_o   sigma0(sig0Src_i)
//   sigma1_o   sigma1(sig1Src_i)
// DATA_WIDTH selects the 32-bit or 64-bit rotate/shift amounts.
// ---------------------------------------------------------------------------
module msg_sigma
    import sha2_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] sig0Src_i,
    input  logic [DATA_WIDTH-1:0] sig1Src_i,
    output logic [DATA_WIDTH-1:0] sigma0_o,
    output logic [DATA_WIDTH-1:0] sigma1_o
);

    localparam bit WIDE = (DATA_WIDTH == 64);

    localparam int S0A = WIDE ? S0_ROT_A_512 : S0_ROT_A_256;
    localparam int S0B = WIDE ? S0_ROT_B_512 : S0_ROT_B_256;
    localparam int S0S = WIDE ? S0_SHR_512   : S0_SHR_256;
    localparam int S1A = WIDE ? S1_ROT_A_512 : S1_ROT_A_256;
    localparam int S1B = WIDE ? S1_ROT_B_512 : S1_ROT_B_256;
    localparam int S1S = WIDE ? S1_SHR_512   : S1_SHR_256;

    // Rotate right by a constant; the two shifted halves never overlap.
    function automatic logic [DATA_WIDTH-1:0] rotr(input logic [DATA_WIDTH-1:0] x,
                                                   input int n);
        return (x >> n) | (x << (DATA_WIDTH - n));
    endfunction

    // Each sigma is two rotates and one logical shift folded by XOR.
    assign sigma0_o = rotr(sig0Src_i, S0A) ^ rotr(sig0Src_i, S0B) ^ (sig0Src_i >> S0S);
    assign sigma1_o = rotr(sig1Src_i, S1A) ^ rotr(sig1Src_i, S1B) ^ (sig1Src_i >> S1S);

endmodule

// File: rtl/msg_sched.sv
// ---------------------------------------------------------------------------
// msg_sched
// SHA-2 message scheduler. Accepts sixteen message words of one block over a
// valid/ready stream, then emits the whole schedule W[0..ROUNDS-1] over a
// second valid/ready stream using a sixteen-word sliding window.
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   start_in          begin a new block (only acted on while idle)
//   flush_in          synchronous abort back to idle from any state
//   in_valid/in_data  incoming message words, W[0] first
//   in_ready          high while the window is being filled
//   out_valid/out_data/out_ready  schedule word stream, W[out_idx]
//   out_idx           index t of the word on out_data
//   out_last          marks W[ROUNDS-1]
//   done_out          single-cycle pulse after the final output handshake
//   busy_out          high whenever a block is in progress
// ---------------------------------------------------------------------------
module msg_sched
    import sha2_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ROUNDS     = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_in,
    input  logic                  flush_in,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [6:0]            out_idx,
    output logic                  out_last,
    output logic                  done_out,
    output logic                  busy_out
);

    // Only the two SHA-2 word widths with their matching schedule lengths
    // make sense; anything else is rejected while elaborating.
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : gBadWidth
        $error("msg_sched: DATA_WIDTH must be 32 or 64");
    end
    if (ROUNDS != roundsFor(DATA_WIDTH)) begin : gBadRounds
        $error("msg_sched: ROUNDS does not match DATA_WIDTH");
    end

    localparam logic [6:0] LAST_IDX  = 7'(ROUNDS - 1);
    localparam logic [6:0] LAST_LOAD = 7'(WINDOW_WORDS - 1);

    state_e                state_q;
    logic [6:0]            cnt_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] window_q [WINDOW_WORDS];

    logic [DATA_WIDTH-1:0] sigma0;
    logic [DATA_WIDTH-1:0] sigma1;
    logic [DATA_WIDTH-1:0] wNew_d;

    // window[1] is W[t-15] and window[14] is W[t-2] relative to the word
    // W[t+16] being appended, so one sigma pair serves every step.
    msg_sigma #(
        .DATA_WIDTH(DATA_WIDTH)
    ) uSigma (
        .sig0Src_i(window_q[1]),
        .sig1Src_i(window_q[14]),
        .sigma0_o (sigma0),
        .sigma1_o (sigma1)
    );

    // Next word appended to the top of the window; wraps modulo 2^DATA_WIDTH.
    assign wNew_d = sigma1 + window_q[9] + sigma0 + window_q[0];

    // Control FSM, counter and window. A flush returns to idle without
    // touching the window and without a done pulse; only the reset clears
    // the window contents. The recurrence is applied on every output
    // handshake, including the first sixteen, because the original message
    // words simply shift down and out unchanged while W[16..] are appended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < WINDOW_WORDS; k++) begin
                window_q[k] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (flush_in) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_in) begin
                            state_q <= LOAD;
                            cnt_q   <= '0;
                        end
                    end
                    LOAD: begin
                        if (in_valid) begin
                            window_q[cnt_q[3:0]] <= in_data;
                            if (cnt_q == LAST_LOAD) begin
                                state_q <= EXPAND;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 7'd1;
                            end
                        end
                    end
                    EXPAND: begin
                        if (out_ready) begin
                            for (int k = 0; k < WINDOW_WORDS - 1; k++) begin
                                window_q[k] <= window_q[k+1];
                            end
                            window_q[WINDOW_WORDS-1] <= wNew_d;
                            if (cnt_q == LAST_IDX) begin
                                state_q <= IDLE;
                                cnt_q   <= '0;
                                done_q  <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + 7'd1;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    // Outputs are decodes of registered state only; data and index are
    // forced to zero whenever no word is being offered.
    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == EXPAND);
    assign out_data  = out_valid ? window_q[0] : '0;
    assign out_idx   = out_valid ? cnt_q : 7'd0;
    assign out_last  = out_valid && (cnt_q == LAST_IDX);
    assign done_out  = done_q;
    assign busy_out  = (state_q != IDLE);

endmodule

// File: tb/tb_msg_sched.sv
// ---------------------------------------------------------------------------
// tb_msg_sched
// Self-checking bench for msg_sched. One 32-bit and one 64-bit instance share
// the clock and reset. Expected schedules come from the textbook recurrence
// W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] evaluated over a flat
// array of all ROUNDS words.
// ---------------------------------------------------------------------------
module tb_msg_sched;

    localparam int ROUNDS32 = 64;
    localparam int ROUNDS64 = 80;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    int unsigned cyc   = 0;

    logic        startA = 1'b0, flushA = 1'b0, inValidA = 1'b0, outReadyA = 1'b0;
    logic [31:0] inDataA = '0;
    logic        inReadyA, outValidA, outLastA, doneA, busyA;
    logic [31:0] outDataA;
    logic [6:0]  outIdxA;

    logic        startB = 1'b0, flushB = 1'b0, inValidB = 1'b0, outReadyB = 1'b0;
    logic [63:0] inDataB = '0;
    logic        inReadyB, outValidB, outLastB, doneB, busyB;
    logic [63:0] outDataB;
    logic [6:0]  outIdxB;

    int errors = 0;
    int checks = 0;

    logic [63:0] msgW [16];
    logic [63:0] expW [80];

    msg_sched #(.DATA_WIDTH(32), .ROUNDS(ROUNDS32)) dutA (
        .clk(clk), .rst_n(rst_n), .start_in(startA), .flush_in(flushA),
        .in_valid(inValidA), .in_data(inDataA), .in_ready(inReadyA),
        .out_valid(outValidA), .out_data(outDataA), .out_ready(outReadyA),
        .out_idx(outIdxA), .out_last(outLastA), .done_out(doneA), .busy_out(busyA)
    );

    msg_sched #(.DATA_WIDTH(64), .ROUNDS(ROUNDS64)) dutB (
        .clk(clk), .rst_n(rst_n), .start_in(startB), .flush_in(flushB),
        .in_valid(inValidB), .in_data(inDataB), .in_ready(inReadyB),
        .out_valid(outValidB), .out_data(outDataB), .out_ready(outReadyB),
        .out_idx(outIdxB), .out_last(outLastB), .done_out(doneB), .busy_out(busyB)
    );

    // Free-running clock plus a cycle counter used for latency checks.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference arithmetic on 64-bit containers, masked to the word width.
    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
        logic [63:0] v;
        v = x & wmask(w);
        return ((v >> n) | (v << (w - n))) & wmask(w);
    endfunction

    task automatic computeExpected(input int w, input int r);
        logic [63:0] s0, s1, a, b;
        for (int t = 0; t < 16; t++) expW[t] = msgW[t] & wmask(w);
        for (int t = 16; t < r; t++) begin
            a = expW[t-15];
            b = expW[t-2];
            if (w == 32) begin
                s0 = rotr(a, 7, 32) ^ rotr(a, 18, 32) ^ (a >> 3);
                s1 = rotr(b, 17, 32) ^ rotr(b, 19, 32) ^ (b >> 10);
            end else begin
                s0 = rotr(a, 1, 64) ^ rotr(a, 8, 64) ^ (a >> 7);
                s1 = rotr(b, 19, 64) ^ rotr(b, 61, 64) ^ (b >> 6);
            end
            expW[t] = (s1 + expW[t-7] + s0 + expW[t-16]) & wmask(w);
        end
    endtask

    task automatic randomMessage();
        for (int i = 0; i < 16; i++) msgW[i] = {$urandom, $urandom};
    endtask

    task automatic abcMessage(input int w);
        for (int i = 0; i < 16; i++) msgW[i] = '0;
        msgW[0]  = (w == 32) ? 64'h0000_0000_6162_6380 : 64'h6162_6380_0000_0000;
        msgW[15] = (w == 32) ? 64'h18 : 64'h18;
    endtask

    // Runs one block through the 32-bit instance with random in_valid and
    // out_ready duty cycles, checking every offered word against the model.
    // flushAt >= 0 aborts the block while W[flushAt] is on the output.
    task automatic runA(input int inPct, input int outPct, input int flushAt,
                        input bit pokeStart, input bit timeIt);
        int acc, t;
        int unsigned s;
        bit pv, pr, ov, orq, flushing, finished;
        computeExpected(32, ROUNDS32);
        @(negedge clk);
        startA = 1'b1;
        s = cyc;
        @(negedge clk);
        startA = 1'b0;
        checks++;
        if (inReadyA !== 1'b1) begin
            errors++;
            $display("[TB] FAIL a_start_ready: in_ready=%b expected 1", inReadyA);
        end
        acc = 0; t = 0; pv = 0; pr = 0; ov = 0; orq = 0; flushing = 0; finished = 0;
        for (int n = 0; n < 3000 && !finished; n++) begin
            if (n > 0) @(negedge clk);
            if (flushing) begin
                flushA = 1'b0; outReadyA = 1'b0; inValidA = 1'b0; startA = 1'b0;
                checks++;
                if (busyA !== 1'b0 || outValidA !== 1'b0 || doneA !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL a_flush_idle: busy=%b out_valid=%b done=%b expected 0 0 0",
                             busyA, outValidA, doneA);
                end
                @(negedge clk);
                checks++;
                if (doneA !== 1'b0 || busyA !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL a_flush_nodone: done=%b busy=%b expected 0 0", doneA, busyA);
                end
                finished = 1;
            end else begin
                if (pv && pr) acc++;
                if (ov && orq) t++;
                if (t == ROUNDS32) begin
                    outReadyA = 1'b0; inValidA = 1'b0; startA = 1'b0;
                    checks++;
                    if (doneA !== 1'b1 || outValidA !== 1'b0 || busyA !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL a_done: done=%b out_valid=%b busy=%b expected 1 0 0",
                                 doneA, outValidA, busyA);
                    end
                    if (timeIt) begin
                        checks++;
                        if (cyc - s !== 32'(17 + ROUNDS32)) begin
                            errors++;
                            $display("[TB] FAIL a_latency: cycles=%0d expected %0d", cyc - s, 17 + ROUNDS32);
                        end
                    end
                    @(negedge clk);
                    checks++;
                    if (doneA !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL a_done_pulse: done=%b expected 0", doneA);
                    end
                    finished = 1;
                end else begin
                    checks++;
                    if (doneA !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL a_early_done: t=%0d done=%b expected 0", t, doneA);
                    end
                    checks++;
                    if (acc == 16) begin
                        if (outValidA !== 1'b1 || outDataA !== 32'(expW[t]) ||
                            outIdxA !== 7'(t) || outLastA !== (t == ROUNDS32 - 1)) begin
                            errors++;
                            $display("[TB] FAIL a_word: t=%0d got v=%b d=%h i=%0d l=%b expected v=1 d=%h i=%0d l=%b",
                                     t, outValidA, outDataA, outIdxA, outLastA,
                                     32'(expW[t]), t, (t == ROUNDS32 - 1));
                        end
                    end else if (outValidA !== 1'b0 || outDataA !== 32'd0 || outIdxA !== 7'd0) begin
                        errors++;
                        $display("[TB] FAIL a_load_quiet: acc=%0d out_valid=%b data=%h idx=%0d expected 0 0 0",
                                 acc, outValidA, outDataA, outIdxA);
                    end
                    pr  = inReadyA;
                    ov  = outValidA;
                    pv  = (acc < 16) && ($urandom_range(0, 99) < inPct);
                    orq = ($urandom_range(0, 99) < outPct);
                    outReadyA = orq;
                    if (acc < 16) begin
                        inValidA = pv;
                        inDataA  = pv ? 32'(msgW[acc]) : $urandom;
                    end else begin
                        inValidA = 1'($urandom_range(0, 1));
                        inDataA  = $urandom;
                    end
                    startA = pokeStart && (acc == 16) && ($urandom_range(0, 3) == 0);
                    if (flushAt >= 0 && acc == 16 && t == flushAt && outValidA) begin
                        flushA   = 1'b1;
                        flushing = 1;
                    end
                end
            end
        end
        inValidA = 1'b0; outReadyA = 1'b0; startA = 1'b0; flushA = 1'b0;
        if (!finished) begin
            errors++;
            $display("[TB] FAIL a_timeout: acc=%0d t=%0d expected block to complete", acc, t);
        end
    endtask

    // Full-rate block through the 64-bit instance.
    task automatic runB();
        int acc, t;
        int unsigned s;
        bit finished;
        computeExpected(64, ROUNDS64);
        @(negedge clk);
        startB = 1'b1;
        s = cyc;
        @(negedge clk);
        startB = 1'b0;
        outReadyB = 1'b1;
        acc = 0; t = 0; finished = 0;
        for (int n = 0; n < 500 && !finished; n++) begin
            if (n > 0) @(negedge clk);
            if (acc < 16) begin
                checks++;
                if (inReadyB !== 1'b1 || outValidB !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b_load: acc=%0d in_ready=%b out_valid=%b expected 1 0",
                             acc, inReadyB, outValidB);
                end
                inValidB = 1'b1;
                inDataB  = msgW[acc];
                acc++;
            end else if (t < ROUNDS64) begin
                inValidB = 1'b0;
                checks++;
                if (outValidB !== 1'b1 || outDataB !== expW[t] || outIdxB !== 7'(t) ||
                    outLastB !== (t == ROUNDS64 - 1) || doneB !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b_word: t=%0d got v=%b d=%h i=%0d l=%b done=%b expected v=1 d=%h i=%0d l=%b done=0",
                             t, outValidB, outDataB, outIdxB, outLastB, doneB,
                             expW[t], t, (t == ROUNDS64 - 1));
                end
                t++;
            end else begin
                outReadyB = 1'b0;
                checks++;
                if (doneB !== 1'b1 || busyB !== 1'b0 || cyc - s !== 32'(17 + ROUNDS64)) begin
                    errors++;
                    $display("[TB] FAIL b_done: done=%b busy=%b cycles=%0d expected 1 0 %0d",
                             doneB, busyB, cyc - s, 17 + ROUNDS64);
                end
                finished = 1;
            end
        end
        inValidB = 1'b0; outReadyB = 1'b0;
        if (!finished) begin
            errors++;
            $display("[TB] FAIL b_timeout: t=%0d expected block to complete", t);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({inReadyA, outValidA, outLastA, doneA, busyA} !== 5'b0 || outDataA !== 32'd0 ||
            outIdxA !== 7'd0 || {inReadyB, outValidB, outLastB, doneB, busyB} !== 5'b0 ||
            outDataB !== 64'd0 || outIdxB !== 7'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: A flags=%b data=%h idx=%0d B flags=%b data=%h idx=%0d expected all 0",
                     {inReadyA, outValidA, outLastA, doneA, busyA}, outDataA, outIdxA,
                     {inReadyB, outValidB, outLastB, doneB, busyB}, outDataB, outIdxB);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abc32();
        abcMessage(32);
        computeExpected(32, ROUNDS32);
        checks++;
        if (expW[16] !== 64'h6162_6380 || expW[17] !== 64'h000F_0000) begin
            errors++;
            $display("[TB] FAIL abc32_model: W16=%h W17=%h expected 61626380 000f0000", expW[16], expW[17]);
        end
        runA(100, 100, -1, 1'b0, 1'b1);
    endtask

    task automatic test_abc64();
        abcMessage(64);
        computeExpected(64, ROUNDS64);
        checks++;
        if (expW[16] !== 64'h6162_6380_0000_0000 || expW[17] !== 64'h0003_0000_0000_00C0) begin
            errors++;
            $display("[TB] FAIL abc64_model: W16=%h W17=%h expected 6162638000000000 00030000000000c0",
                     expW[16], expW[17]);
        end
        runB();
    endtask

    task automatic test_random_gaps();
        for (int b = 0; b < 3; b++) begin
            randomMessage();
            runA(50, 50, -1, 1'b0, 1'b0);
        end
        randomMessage();
        runB();
    endtask

    task automatic test_flush();
        randomMessage();
        runA(100, 70, 20, 1'b0, 1'b0);
        randomMessage();
        runA(100, 100, -1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midload();
        @(negedge clk);
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        for (int i = 0; i < 7; i++) begin
            inValidA = 1'b1;
            inDataA  = $urandom;
            @(negedge clk);
        end
        inValidA = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({inReadyA, outValidA, outLastA, doneA, busyA} !== 5'b0 ||
            outDataA !== 32'd0 || outIdxA !== 7'd0) begin
            errors++;
            $display("[TB] FAIL midload_reset: flags=%b data=%h idx=%0d expected all 0",
                     {inReadyA, outValidA, outLastA, doneA, busyA}, outDataA, outIdxA);
        end
        @(negedge clk);
        rst_n = 1'b1;
        randomMessage();
        runA(100, 100, -1, 1'b0, 1'b1);
    endtask

    task automatic test_idle_ignore();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (inReadyA !== 1'b0 || busyA !== 1'b0 || outValidA !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_valid: in_ready=%b busy=%b out_valid=%b expected 0 0 0",
                         inReadyA, busyA, outValidA);
            end
            inValidA = 1'b1;
            inDataA  = $urandom;
        end
        @(negedge clk);
        inValidA = 1'b0;
        startA   = 1'b1;
        flushA   = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        flushA = 1'b0;
        checks++;
        if (busyA !== 1'b0 || inReadyA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_flush_idle: busy=%b in_ready=%b expected 0 0", busyA, inReadyA);
        end
        randomMessage();
        runA(100, 100, -1, 1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_abc32();
        test_abc64();
        test_random_gaps();
        test_flush();
        test_reset_midload();
        test_idle_ignore();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
